bcd_conv_arbiter: RTL and testbench

- Shares one binary2bcd converter instance among N_REQ requesters, e.g. several temperature or measurement channels that each need a decimal display value.
- Grants requesters round-robin and latches the winner's binary operand.
- Issues a one-cycle start to the converter, waits for its valid pulse (with a watchdog), then returns the BCD result with a one-cycle ack to the granted requester.
- Sits between the channel front-ends and the single converter instance.

---
 rtl/bcd_conv_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter
//
// Shares a single binary-to-BCD converter among N_REQ requesters. A requester
// is granted round-robin, its operand is latched and presented to the
// converter, a one-cycle start pulse is issued, and the BCD result (or a
// timeout error) is returned with a one-cycle, one-hot ack to that requester.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req        per-requester request level
//   din        packed operands, requester i at [i*DIN_W +: DIN_W]
//   ack        one-cycle completion pulse, one-hot
//   dout       BCD result, valid while any ack bit is high (held otherwise)
//   dout_id    index of the requester being acked
//   err        high together with ack when the converter timed out
//   busy       high in every state except IDLE
//   conv_en    one-cycle start pulse to the converter
//   conv_din   operand to the converter (stable for the whole transaction)
//   conv_dout  converter BCD result
//   conv_vld   converter result-valid pulse
// -----------------------------------------------------------------------------
module bcd_conv_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DIN_W   = 19,
   parameter int DOUT_W  = 24,
   parameter int TIMEOUT = 63
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*DIN_W-1:0]     din,
   output logic [N_REQ-1:0]           ack,
   output logic [DOUT_W-1:0]          dout,
   output logic [$clog2(N_REQ)-1:0]   dout_id,
   output logic                       err,
   output logic                       busy,
   output logic                       conv_en,
   output logic [DIN_W-1:0]           conv_din,
   input  logic [DOUT_W-1:0]          conv_dout,
   input  logic                       conv_vld
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   // One extra bit so rr_ptr + k (k <= N_REQ) never overflows before the wrap.
   localparam logic [ID_W:0]    N_REQ_C   = N_REQ[ID_W:0];
   localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [DIN_W-1:0]  op_q;
   logic [CNT_W-1:0]  wait_cnt_q;

   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [DOUT_W-1:0] dout_q, dout_d;
   logic [ID_W-1:0]   dout_id_q, dout_id_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              conv_en_q, conv_en_d;

   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W:0]     cand;
   logic              wait_done;

   // Unpack the operand bus so the grant index can select a lane directly.
   logic [DIN_W-1:0]  din_arr [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign din_arr[gi] = din[gi*DIN_W +: DIN_W];
      end
   endgenerate

   // Round-robin search: first set req bit starting at rr_ptr+1, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + k[ID_W:0];
         if (cand >= N_REQ_C) begin
            cand = cand - N_REQ_C;
         end
         if (!grant_vld && req[cand[ID_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   // Leaving WAIT happens on a converter result or on the watchdog limit.
   assign wait_done = conv_vld || (wait_cnt_q == TIMEOUT_C);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_vld) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (wait_done) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------ output logic
   // Outputs are registered, so their next values are derived from state_d:
   // the response fields are loaded on the WAIT->RESP transition and appear
   // during the RESP cycle itself.
   always_comb begin
      ack_d     = '0;
      dout_d    = dout_q;
      dout_id_d = dout_id_q;
      err_d     = 1'b0;
      busy_d    = (state_d != S_IDLE);
      conv_en_d = (state_d == S_ISSUE);
      if (state_q == S_WAIT && state_d == S_RESP) begin
         ack_d[id_q] = 1'b1;
         dout_id_d   = id_q;
         // A result arriving on the watchdog cycle still wins over the error.
         dout_d      = conv_vld ? conv_dout : '0;
         err_d       = !conv_vld;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q     <= '0;
         dout_q    <= '0;
         dout_id_q <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         conv_en_q <= 1'b0;
      end else begin
         ack_q     <= ack_d;
         dout_q    <= dout_d;
         dout_id_q <= dout_id_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         conv_en_q <= conv_en_d;
      end
   end

   // ---------------------------------------------------------------- datapath
   // Reset leaves rr_ptr on the last index so the first grant searches from 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= ID_W'(N_REQ - 1);
         id_q       <= '0;
         op_q       <= '0;
         wait_cnt_q <= '0;
      end else begin
         if (state_q == S_IDLE && grant_vld) begin
            rr_ptr_q <= grant_idx;
            id_q     <= grant_idx;
            op_q     <= din_arr[grant_idx];
         end
         if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end else if (state_q == S_RESP) begin
            wait_cnt_q <= '0;
         end
      end
   end

   assign ack      = ack_q;
   assign dout     = dout_q;
   assign dout_id  = dout_id_q;
   assign err      = err_q;
   assign busy     = busy_q;
   assign conv_en  = conv_en_q;
   assign conv_din = op_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

   localparam int N_REQ   = 4;
   localparam int DIN_W   = 19;
   localparam int DOUT_W  = 24;
   localparam int TIMEOUT = 63;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [N_REQ-1:0]         req;
   logic [N_REQ*DIN_W-1:0]   din;
   logic [N_REQ-1:0]         ack;
   logic [DOUT_W-1:0]        dout;
   logic [ID_W-1:0]          dout_id;
   logic                     err;
   logic                     busy;
   logic                     conv_en;
   logic [DIN_W-1:0]         conv_din;
   logic [DOUT_W-1:0]        conv_dout;
   logic                     conv_vld;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bcd_conv_arbiter #(
      .N_REQ(N_REQ), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .din(din),
      .ack(ack), .dout(dout), .dout_id(dout_id), .err(err), .busy(busy),
      .conv_en(conv_en), .conv_din(conv_din),
      .conv_dout(conv_dout), .conv_vld(conv_vld)
   );

   // ---------------- converter stub: vld DIN_W+2 cycles after the en cycle
   logic              stub_en;
   logic              stub_busy;
   logic              stub_vld;
   logic              stray_vld;
   int                stub_cnt;
   logic [DOUT_W-1:0] stub_dout;

   function automatic logic [DOUT_W-1:0] to_bcd(input logic [DIN_W-1:0] v);
      logic [DOUT_W-1:0] r;
      int unsigned       x;
      r = '0;
      x = v;
      for (int d = 0; d < DOUT_W/4; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_busy <= 1'b0;
         stub_cnt  <= 0;
         stub_vld  <= 1'b0;
         stub_dout <= '0;
      end else begin
         stub_vld <= 1'b0;
         if (!stub_busy) begin
            if (conv_en && stub_en) begin
               stub_busy <= 1'b1;
               stub_cnt  <= 1;
               stub_dout <= to_bcd(conv_din);
            end
         end else if (stub_vld) begin
            stub_busy <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 == DIN_W + 2) stub_vld <= 1'b1;
         end
      end
   end

   assign conv_dout = stub_dout;
   assign conv_vld  = stub_vld | stray_vld;

   // ---------------- event counters
   int ack_count = 0;
   int en_count  = 0;
   always @(posedge clk) begin
      if (|ack)   ack_count <= ack_count + 1;
      if (conv_en) en_count <= en_count + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts edges until an ack is visible (bounded); n==200 means none came.
   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (ack == '0 && n < 200);
   endtask

   int n;
   int snap;
   logic [DOUT_W-1:0] exp_dout [4];
   logic [1:0]        exp_id   [4];

   initial begin
      rst       = 1'b1;
      req       = '0;
      din       = '0;
      stub_en   = 1'b1;
      stray_vld = 1'b0;

      // ---------------- reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack",      64'(ack),      64'h0);
      check("rst_dout",     64'(dout),     64'h0);
      check("rst_dout_id",  64'(dout_id),  64'h0);
      check("rst_err",      64'(err),      64'h0);
      check("rst_busy",     64'(busy),     64'h0);
      check("rst_conv_en",  64'(conv_en),  64'h0);
      check("rst_conv_din", 64'(conv_din), 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ---------------- single request: req[2], 151
      snap = en_count;
      din[2*DIN_W +: DIN_W] = 19'd151;
      req = 4'b0100;
      wait_ack(n);
      $display("[TB] single: ack=%b dout=%h id=%0d err=%b at cycle %0d", ack, dout, dout_id, err, n);
      check("single_latency", 64'(n),        64'd23);
      check("single_ack",     64'(ack),      64'b0100);
      check("single_dout",    64'(dout),     64'h000151);
      check("single_id",      64'(dout_id),  64'd2);
      check("single_err",     64'(err),      64'h0);
      check("single_busy",    64'(busy),     64'h1);
      check("single_conv_din",64'(conv_din), 64'd151);
      req = '0;
      @(posedge clk);
      #1;
      check("single_ack_pulse", 64'(ack),  64'h0);
      check("single_idle_busy", 64'(busy), 64'h0);
      check("single_en_pulses", 64'(en_count - snap), 64'd1);

      // ---------------- max operand on req[0]
      din[0 +: DIN_W] = 19'd524287;
      req = 4'b0001;
      wait_ack(n);
      $display("[TB] max: ack=%b dout=%h id=%0d err=%b at cycle %0d", ack, dout, dout_id, err, n);
      check("max_latency", 64'(n),    64'd23);
      check("max_ack",     64'(ack),  64'b0001);
      check("max_dout",    64'(dout), 64'h524287);
      req = '0;
      @(posedge clk);
      #1;

      // ---------------- timeout: converter never answers
      stub_en = 1'b0;
      din[1*DIN_W +: DIN_W] = 19'd77;
      req = 4'b0010;
      wait_ack(n);
      $display("[TB] timeout: ack=%b dout=%h id=%0d err=%b at cycle %0d", ack, dout, dout_id, err, n);
      check("to_latency", 64'(n),       64'd66);
      check("to_ack",     64'(ack),     64'b0010);
      check("to_err",     64'(err),     64'h1);
      check("to_dout",    64'(dout),    64'h0);
      check("to_id",      64'(dout_id), 64'd1);
      req = '0;
      @(posedge clk);
      #1;
      snap = ack_count;
      stray_vld = 1'b1;
      @(posedge clk);
      #1;
      stray_vld = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      $display("[TB] stray vld: acks after=%0d busy=%b", ack_count - snap, busy);
      check("stray_no_ack", 64'(ack_count - snap), 64'd0);
      check("stray_busy",   64'(busy),             64'h0);
      stub_en = 1'b1;

      // ---------------- reset mid-WAIT
      din[3*DIN_W +: DIN_W] = 19'd5;
      req = 4'b1000;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy_before", 64'(busy), 64'h1);
      snap = ack_count;
      rst = 1'b1;
      #1;
      $display("[TB] reset mid-wait: busy=%b conv_din=%0d dout_id=%0d", busy, conv_din, dout_id);
      check("mid_rst_busy",     64'(busy),     64'h0);
      check("mid_rst_ack",      64'(ack),      64'h0);
      check("mid_rst_conv_din", 64'(conv_din), 64'h0);
      check("mid_rst_dout_id",  64'(dout_id),  64'h0);
      check("mid_rst_conv_en",  64'(conv_en),  64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      repeat (30) @(posedge clk);
      #1;
      check("mid_no_ack", 64'(ack_count - snap), 64'd0);

      // ---------------- contention after reset: order 0,1,2,3
      din[0*DIN_W +: DIN_W] = 19'd10;
      din[1*DIN_W +: DIN_W] = 19'd20;
      din[2*DIN_W +: DIN_W] = 19'd30;
      din[3*DIN_W +: DIN_W] = 19'd40;
      exp_dout[0] = 24'h000010;
      exp_dout[1] = 24'h000020;
      exp_dout[2] = 24'h000030;
      exp_dout[3] = 24'h000040;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_ack(n);
         $display("[TB] contention %0d: ack=%b dout=%h id=%0d after %0d cycles", i, ack, dout, dout_id, n);
         check($sformatf("cont%0d_spacing", i), 64'(n),       (i == 0) ? 64'd23 : 64'd24);
         check($sformatf("cont%0d_ack", i),     64'(ack),     64'(4'b0001 << i));
         check($sformatf("cont%0d_dout", i),    64'(dout),    64'(exp_dout[i]));
         check($sformatf("cont%0d_id", i),      64'(dout_id), 64'(i));
         req[i] = 1'b0;
      end

      // ---------------- fairness: req[0] and req[3] both kept asserted
      din[0*DIN_W +: DIN_W] = 19'd7;
      din[3*DIN_W +: DIN_W] = 19'd3;
      exp_id[0] = 2'd0; exp_dout[0] = 24'h000007;
      exp_id[1] = 2'd3; exp_dout[1] = 24'h000003;
      exp_id[2] = 2'd0; exp_dout[2] = 24'h000007;
      exp_id[3] = 2'd3; exp_dout[3] = 24'h000003;
      @(posedge clk);
      #1;
      req = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         wait_ack(n);
         if (i == 3) req = '0;
         $display("[TB] fairness %0d: ack=%b dout=%h id=%0d after %0d cycles", i, ack, dout, dout_id, n);
         check($sformatf("fair%0d_spacing", i), 64'(n),       (i == 0) ? 64'd23 : 64'd24);
         check($sformatf("fair%0d_id", i),      64'(dout_id), 64'(exp_id[i]));
         check($sformatf("fair%0d_dout", i),    64'(dout),    64'(exp_dout[i]));
      end
      repeat (3) @(posedge clk);
      #1;
      check("final_busy", 64'(busy), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
